// File: rtl/state_trace_monitor.sv
// Monitors the {FA,FB} state stream: per-state entry counters, 00->01->11->10 walk detector,
// stall flag and counter readout. Define STATE_TRACE_HISTORY_EN to build the 4-deep state history.
module state_trace_monitor #(
  parameter int CNT_W     = 8,
  parameter int STALL_CYC = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       state_in,
  input  logic             clr,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out,
  output logic             seq_hit,
  output logic             stall,
  output logic [7:0]       hist
);

  // state | meaning
  // IDLE  | no partial walk in progress
  // G1    | 00->01 seen
  // G2    | 00->01->11 seen; a following 10 completes the walk
  typedef enum logic [1:0] {IDLE = 2'd0, G1 = 2'd1, G2 = 2'd2} seq_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] STALL_MAX = STALL_CYC[CNT_W-1:0];

  logic [1:0]       prev_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_q;
  logic             seq_hit_q, hit_d;
  seq_state_e       fsm_q, fsm_d;
  logic             chg;

  assign chg = (state_in != prev_q);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (clr) begin
      for (int i = 0; i < 4; i++) begin
        cnt_d[i] = '0;
      end
    end else if (chg && (cnt_q[state_in] != CNT_MAX)) begin
      cnt_d[state_in] = cnt_q[state_in] + 1'b1;
    end
  end

  // Readout samples the pre-update counter; clr forces zero straight away.
  always_comb begin
    cnt_out_d = clr ? '0 : cnt_q[cnt_sel];
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr || chg) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != STALL_MAX) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // FSM next-state; the walk only advances on a sampled change.
  always_comb begin
    fsm_d = fsm_q;
    if (clr) begin
      fsm_d = IDLE;
    end else if (chg) begin
      if ((prev_q == 2'b00) && (state_in == 2'b01)) begin
        fsm_d = G1;
      end else if ((fsm_q == G1) && (state_in == 2'b11)) begin
        fsm_d = G2;
      end else begin
        fsm_d = IDLE;
      end
    end
  end

  always_comb begin
    hit_d = 1'b0;
    if (!clr && chg && (fsm_q == G2) && (state_in == 2'b10)) begin
      hit_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q      <= 2'b00;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      cnt_out_q   <= '0;
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
      seq_hit_q   <= 1'b0;
    end else begin
      prev_q      <= state_in;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      cnt_out_q   <= cnt_out_d;
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= (stall_cnt_q == STALL_MAX);
      seq_hit_q   <= hit_d;
    end
  end

  assign cnt_out = cnt_out_q;
  assign seq_hit = seq_hit_q;
  assign stall   = stall_q;

`ifdef STATE_TRACE_HISTORY_EN
  logic [7:0] hist_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_q <= 8'h00;
    end else if (clr) begin
      hist_q <= 8'h00;
    end else if (chg) begin
      hist_q <= {hist_q[5:0], state_in};
    end
  end

  assign hist = hist_q;
`else
  assign hist = 8'h00;
`endif

endmodule

// File: tb/tb_state_trace_monitor.sv
// Directed self-checking bench for state_trace_monitor (CNT_W=8, STALL_CYC=6).
module tb_state_trace_monitor;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] state_in;
  logic       clr;
  logic [1:0] cnt_sel;
  logic [7:0] cnt_out;
  logic       seq_hit;
  logic       stall;
  logic [7:0] hist;

  int tests_run = 0;
  int tests_failed = 0;

  state_trace_monitor #(.CNT_W(8), .STALL_CYC(6)) dut (
    .clock    (clock),
    .reset    (reset),
    .state_in (state_in),
    .clr      (clr),
    .cnt_sel  (cnt_sel),
    .cnt_out  (cnt_out),
    .seq_hit  (seq_hit),
    .stall    (stall),
    .hist     (hist)
  );

  always #5 clock = ~clock;

  task automatic step(input logic [1:0] s);
    state_in = s;
    @(posedge clock);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clock);
    #1;
    clr = 1'b0;
  endtask

  task automatic read_cnt(input logic [1:0] sel, output logic [7:0] v);
    cnt_sel = sel;
    @(posedge clock);
    #1;
    v = cnt_out;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1'b0; state_in = 2'b00; clr = 1'b0; cnt_sel = 2'b00;
    #12;
    tests_run++;
    if ({cnt_out, seq_hit, stall, hist} !== 18'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got cnt=%0d hit=%0b stall=%0b hist=%0h expected all 0",
               cnt_out, seq_hit, stall, hist);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(2'b00);
      tests_run++;
      if (stall !== (i >= 7) || seq_hit !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_stall_edge%0d: got stall=%0b hit=%0b expected stall=%0b hit=0",
                 i, stall, seq_hit, (i >= 7));
      end
    end
    for (int s = 0; s < 4; s++) begin
      read_cnt(s[1:0], v);
      tests_run++;
      if (v !== 8'd0) begin
        tests_failed++;
        $display("FAIL reset_cnt%0d: got %0d expected 0", s, v);
      end
    end
  endtask

  task automatic test_seq_basic();
    logic [1:0] vec [4] = '{2'b01, 2'b11, 2'b10, 2'b10};
    logic       exp_hit [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] exp_cnt [4] = '{8'd0, 8'd1, 8'd1, 8'd1};
    logic [7:0] v;
    for (int i = 0; i < 4; i++) begin
      step(vec[i]);
      tests_run++;
      if (seq_hit !== exp_hit[i]) begin
        tests_failed++;
        $display("FAIL seq_basic_hit%0d: got %0b expected %0b", i, seq_hit, exp_hit[i]);
      end
    end
    for (int s = 0; s < 4; s++) begin
      read_cnt(s[1:0], v);
      tests_run++;
      if (v !== exp_cnt[s]) begin
        tests_failed++;
        $display("FAIL seq_basic_cnt%0d: got %0d expected %0d", s, v, exp_cnt[s]);
      end
    end
  endtask

  task automatic test_stall();
    step(2'b01);
    for (int k = 1; k <= 7; k++) begin
      step(2'b01);
      tests_run++;
      if (stall !== (k == 7)) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: got %0b expected %0b", k, stall, (k == 7));
      end
    end
    step(2'b00);
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_change_edge: got %0b expected 1", stall);
    end
    step(2'b00);
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_drop: got %0b expected 0", stall);
    end
  endtask

  task automatic test_seq_interrupted();
    logic [1:0] vec [13] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 2'b01, 2'b11, 2'b10,
                             2'b00, 2'b01, 2'b11, 2'b10, 2'b10};
    logic       exp_hit [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic [7:0] exp_cnt [4] = '{8'd3, 8'd4, 8'd2, 8'd3};
    logic [7:0] v;
    state_in = 2'b10;
    step(2'b10);
    do_clr();
    for (int i = 0; i < 13; i++) begin
      step(vec[i]);
      tests_run++;
      if (seq_hit !== exp_hit[i]) begin
        tests_failed++;
        $display("FAIL seq_interrupted_hit%0d: got %0b expected %0b", i, seq_hit, exp_hit[i]);
      end
    end
    for (int s = 0; s < 4; s++) begin
      read_cnt(s[1:0], v);
      tests_run++;
      if (v !== exp_cnt[s]) begin
        tests_failed++;
        $display("FAIL seq_interrupted_cnt%0d: got %0d expected %0d", s, v, exp_cnt[s]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] exp_cnt [4] = '{8'd255, 8'd255, 8'd0, 8'd0};
    logic [7:0] v;
    do_clr();
    step(2'b00);
    for (int i = 0; i < 261; i++) begin
      step(2'b01);
      step(2'b00);
    end
    for (int s = 0; s < 4; s++) begin
      read_cnt(s[1:0], v);
      tests_run++;
      if (v !== exp_cnt[s]) begin
        tests_failed++;
        $display("FAIL saturate_cnt%0d: got %0d expected %0d", s, v, exp_cnt[s]);
      end
    end
  endtask

  task automatic test_clr_priority();
    logic [7:0] v;
    do_clr();
    for (int i = 0; i < 4; i++) begin
      step(2'b01);
      step(2'b11);
    end
    read_cnt(2'd3, v);
    tests_run++;
    if (v !== 8'd4) begin
      tests_failed++;
      $display("FAIL clr_pre_cnt3: got %0d expected 4", v);
    end
    step(2'b00);
    step(2'b01);
    clr = 1'b1;
    state_in = 2'b11;
    @(posedge clock);
    #1;
    clr = 1'b0;
    tests_run++;
    if (cnt_out !== 8'd0 || seq_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_cycle: got cnt=%0d hit=%0b expected cnt=0 hit=0", cnt_out, seq_hit);
    end
    step(2'b10);
    tests_run++;
    if (seq_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_no_hit: got %0b expected 0", seq_hit);
    end
    read_cnt(2'd3, v);
    tests_run++;
    if (v !== 8'd0) begin
      tests_failed++;
      $display("FAIL clr_cnt3: got %0d expected 0", v);
    end
    read_cnt(2'd1, v);
    tests_run++;
    if (v !== 8'd0) begin
      tests_failed++;
      $display("FAIL clr_cnt1: got %0d expected 0", v);
    end
    read_cnt(2'd2, v);
    tests_run++;
    if (v !== 8'd1) begin
      tests_failed++;
      $display("FAIL clr_cnt2: got %0d expected 1", v);
    end
  endtask

  task automatic test_history();
    logic [7:0] exp_hist;
    step(2'b00);
    do_clr();
    tests_run++;
    if (hist !== 8'h00) begin
      tests_failed++;
      $display("FAIL hist_clr: got %b expected 00000000", hist);
    end
    step(2'b01);
    step(2'b11);
    step(2'b10);
`ifdef STATE_TRACE_HISTORY_EN
    exp_hist = 8'b00011110;
`else
    exp_hist = 8'h00;
`endif
    tests_run++;
    if (hist !== exp_hist) begin
      tests_failed++;
      $display("FAIL hist_walk: got %b expected %b", hist, exp_hist);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    do_clr();
    step(2'b00);
    step(2'b01);
    step(2'b11);
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({cnt_out, seq_hit, stall, hist} !== 18'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got cnt=%0d hit=%0b stall=%0b hist=%0h expected all 0",
               cnt_out, seq_hit, stall, hist);
    end
    @(negedge clock);
    reset = 1'b1;
    step(2'b10);
    tests_run++;
    if (seq_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_hit: got %0b expected 0", seq_hit);
    end
    step(2'b10);
    tests_run++;
    if (seq_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_hit2: got %0b expected 0", seq_hit);
    end
    read_cnt(2'd2, v);
    tests_run++;
    if (v !== 8'd1) begin
      tests_failed++;
      $display("FAIL reset_mid_cnt2: got %0d expected 1", v);
    end
    read_cnt(2'd1, v);
    tests_run++;
    if (v !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_cnt1: got %0d expected 0", v);
    end
  endtask

  initial begin
    test_reset();
    test_seq_basic();
    test_stall();
    test_seq_interrupted();
    test_saturate();
    test_clr_priority();
    test_history();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
